ft600_device_model: RTL
=======================

// Module: ft600_device_model
// PURPOSE
// Synthesizable model of the FT600 chip side of the 245 synchronous FIFO bus: the responder our FPGA-side master talks to.
// Buffers host->FPGA bytes (h2f), presented when the master reads. Buffers FPGA->host bytes (f2h), captured when it writes.
// Used in loopback benches and on a second iCE40 to emulate the USB chip without hardware.
// PARAMETERS
// H2F_DEPTH_W  5  log2 of h2f FIFO depth in bytes
// F2H_DEPTH_W  5  log2 of f2h FIFO depth in bytes
// PORTS
// clk        in   1   system clock; also the bus clock
// rst        in   1   synchronous, active-high reset
// h2f_valid  in   1   host byte available
// h2f_data   in   8   host byte
// h2f_ready  out  1   h2f FIFO not full; push on valid&ready
// f2h_valid  out  1   f2h FIFO not empty (first-word fall-through)
// f2h_data   out  8   f2h head byte
// f2h_ready  in   1   host consumes head on valid&ready
// err        out  1   sticky protocol error
// ft_clk     out  1   = clk (continuous assign)
// ft_data    inout 16 lane0=[7:0] carries the first byte, lane1=[15:8] the second
// ft_be      inout 2  be[0] qualifies lane0, be[1] qualifies lane1
// ft_rxf     out  1   active low: h2f data available
// ft_txe     out  1   active low: f2h space for 2 bytes
// ft_oe      in   1   active low: device drives bus
// ft_rd      in   1   active low: read strobe
// ft_wr      in   1   active low: write strobe
// BEHAVIOUR
// - Reset: FIFOs empty, pointers 0, ft_rxf=1, ft_txe=1, err=0, f2h_valid=0, h2f_ready=1. Bus is Z while rst is high.
// - Counts are DEPTH_W+1 bits; pointers wrap mod 2^DEPTH_W. Next count = count + pushes - pops, so a same-cycle push and pop are both honoured.
// - h2f_ready=(h2f_cnt!=max), f2h_valid=(f2h_cnt!=0): combinational.
// - Bus drive: when ft_oe=0 and rst=0, drive combinationally from the h2f head:
//   - cnt>=2: be=11, data={head+1,head}.
//   - cnt==1: be=01, data={8'h00,head}.
//   - cnt==0: be=00, data=0.
//   - When ft_oe=1, ft_data and ft_be are Z.
// - Read beat: posedge with ft_oe=0 & ft_rd=0 & ft_wr=1 pops popcount(be) bytes. A beat while empty is legal: be=00, no pop.
// - Write beat: posedge with ft_wr=0 & ft_oe=1 pushes lane0 if be[0], then lane1 if be[1], in that order.
//   - be=10 pushes lane1 only. be=00 pushes nothing and is not an error.
//   - Any byte that does not fit is dropped and sets err.
// - Contention: ft_oe=0 & ft_wr=0 at a posedge sets err. No push and no pop that cycle.
// - Flags are registered from post-update counts, so they lag by 1 cycle:
//   - ft_rxf <= (h2f_cnt_next==0).
//   - ft_txe <= (free_next<2), where free = 2^F2H_DEPTH_W - f2h_cnt.
// - err is cleared only by rst.
// - No internal state machine; the master sequences oe/rd/wr.
// - Reset mid-transfer: FIFOs flush next cycle and the bus releases immediately.
// TESTING
// - Push 11,22,33; ft_rxf falls 1 clk after first push. oe=0,rd=0 -> beat1 data=0x2211 be=11, beat2 data=0x0033 be=01, then ft_rxf=1.
// - Write beats be=11 data=0xBBAA, then be=10 data=0xCC00 -> f2h emits AA,BB,CC; err=0.
// - f2h_ready=0, write 2-byte beats: txe stays 0 through 30 bytes, 1 at 32 bytes. A further beat -> err=1, count stays 32.
// - h2f_cnt=1, same-cycle host push 44 and 1-byte read beat -> cnt=1, head=44, ft_rxf stays 0.
// - oe=0 & wr=0 with h2f_cnt=3 -> err=1, counts unchanged.
// - rst during a read stream with cnt=10 -> cnt=0, ft_rxf=1, bus Z, err=0.

Source files
------------

// File: rtl/ft600_device_model_if.sv
// FT600-side handshake bundle: host byte streams plus the 245 FIFO strobes and flags.
// The 16-bit data lanes and byte enables stay plain inout ports so tristate resolution happens on ordinary nets.
interface ft600_device_model_if;
  logic       h2f_valid;
  logic [7:0] h2f_data;
  logic       h2f_ready;
  logic       f2h_valid;
  logic [7:0] f2h_data;
  logic       f2h_ready;
  logic       ft_rxf;
  logic       ft_txe;
  logic       ft_oe;
  logic       ft_rd;
  logic       ft_wr;

  modport master (
    output h2f_valid, h2f_data, f2h_ready, ft_oe, ft_rd, ft_wr,
    input  h2f_ready, f2h_valid, f2h_data, ft_rxf, ft_txe
  );

  modport slave (
    input  h2f_valid, h2f_data, f2h_ready, ft_oe, ft_rd, ft_wr,
    output h2f_ready, f2h_valid, f2h_data, ft_rxf, ft_txe
  );
endinterface

// File: rtl/ft600_device_model.sv
// Chip-side model of the FT600 245 synchronous FIFO bus: h2f bytes are served on read beats,
// write beats are captured into the f2h FIFO. The master sequences oe/rd/wr; no internal FSM.
module ft600_device_model #(
  parameter int H2F_DEPTH_W = 5,
  parameter int F2H_DEPTH_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  ft600_device_model_if.slave   bus,
  output logic                  err,
  output logic                  ft_clk,
  inout  wire  [15:0]           ft_data,
  inout  wire  [1:0]            ft_be
);
  localparam int H2F_DEPTH = 1 << H2F_DEPTH_W;
  localparam int F2H_DEPTH = 1 << F2H_DEPTH_W;
  localparam logic [H2F_DEPTH_W:0]   H2F_FULL    = (H2F_DEPTH_W+1)'(H2F_DEPTH);
  localparam logic [H2F_DEPTH_W:0]   H2F_CNT_ONE = (H2F_DEPTH_W+1)'(1);
  localparam logic [H2F_DEPTH_W-1:0] H2F_PTR_ONE = H2F_DEPTH_W'(1);
  localparam logic [F2H_DEPTH_W:0]   F2H_FULL    = (F2H_DEPTH_W+1)'(F2H_DEPTH);
  localparam logic [F2H_DEPTH_W:0]   F2H_CNT_TWO = (F2H_DEPTH_W+1)'(2);

  logic [7:0]             h2f_mem [H2F_DEPTH];
  logic [H2F_DEPTH_W-1:0] h2f_wr_ptr_reg, h2f_rd_ptr_reg, h2f_rd_ptr_1;
  logic [H2F_DEPTH_W:0]   h2f_cnt_reg, h2f_cnt_next;
  logic                   h2f_push;
  logic [1:0]             h2f_pop_n;

  logic [7:0]             f2h_mem [F2H_DEPTH];
  logic [F2H_DEPTH_W-1:0] f2h_wr_ptr_reg, f2h_rd_ptr_reg, f2h_lane1_addr;
  logic [F2H_DEPTH_W:0]   f2h_cnt_reg, f2h_cnt_next, f2h_free;
  logic                   f2h_pop, lane0_req, lane1_req, lane0_ok, lane1_ok, drop;

  logic                   contention, read_beat, write_beat, bus_drive;
  logic [15:0]            drive_data;
  logic [1:0]             drive_be;
  logic                   ft_rxf_reg, ft_txe_reg, err_reg;

  assign ft_clk    = clk;
  // The bus is released the moment rst rises, not one cycle later.
  assign bus_drive = !bus.ft_oe && !rst;
  assign ft_data   = bus_drive ? drive_data : 16'hzzzz;
  assign ft_be     = bus_drive ? drive_be   : 2'bzz;

  assign bus.h2f_ready = (h2f_cnt_reg != H2F_FULL);
  assign bus.f2h_valid = (f2h_cnt_reg != '0);
  assign bus.f2h_data  = f2h_mem[f2h_rd_ptr_reg];
  assign bus.ft_rxf    = ft_rxf_reg;
  assign bus.ft_txe    = ft_txe_reg;
  assign err           = err_reg;

  always_comb begin
    contention = !bus.ft_oe && !bus.ft_wr;
    read_beat  = !bus.ft_oe && !bus.ft_rd && bus.ft_wr;
    write_beat = !bus.ft_wr && bus.ft_oe;

    h2f_rd_ptr_1 = h2f_rd_ptr_reg + H2F_PTR_ONE;
    if (h2f_cnt_reg == '0) begin
      drive_be   = 2'b00;
      drive_data = 16'h0000;
    end else if (h2f_cnt_reg == H2F_CNT_ONE) begin
      drive_be   = 2'b01;
      drive_data = {8'h00, h2f_mem[h2f_rd_ptr_reg]};
    end else begin
      drive_be   = 2'b11;
      drive_data = {h2f_mem[h2f_rd_ptr_1], h2f_mem[h2f_rd_ptr_reg]};
    end

    // A read beat consumes exactly the bytes the enables advertised.
    h2f_pop_n    = read_beat ? ({1'b0, drive_be[0]} + {1'b0, drive_be[1]}) : 2'd0;
    h2f_push     = bus.h2f_valid && bus.h2f_ready;
    h2f_cnt_next = h2f_cnt_reg + (H2F_DEPTH_W+1)'(h2f_push) - (H2F_DEPTH_W+1)'(h2f_pop_n);

    f2h_free       = F2H_FULL - f2h_cnt_reg;
    lane0_req      = write_beat && ft_be[0];
    lane1_req      = write_beat && ft_be[1];
    lane0_ok       = lane0_req && (f2h_free != '0);
    lane1_ok       = lane1_req && (f2h_free > (F2H_DEPTH_W+1)'(lane0_ok));
    drop           = (lane0_req && !lane0_ok) || (lane1_req && !lane1_ok);
    f2h_lane1_addr = f2h_wr_ptr_reg + F2H_DEPTH_W'(lane0_ok);
    f2h_pop        = bus.f2h_valid && bus.f2h_ready;
    f2h_cnt_next   = f2h_cnt_reg + (F2H_DEPTH_W+1)'(lane0_ok) + (F2H_DEPTH_W+1)'(lane1_ok)
                   - (F2H_DEPTH_W+1)'(f2h_pop);
  end

  always_ff @(posedge clk) begin
    if (h2f_push && !rst)
      h2f_mem[h2f_wr_ptr_reg] <= bus.h2f_data;
    if (lane0_ok && !rst)
      f2h_mem[f2h_wr_ptr_reg] <= ft_data[7:0];
    if (lane1_ok && !rst)
      f2h_mem[f2h_lane1_addr] <= ft_data[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h2f_wr_ptr_reg <= '0;
      h2f_rd_ptr_reg <= '0;
      h2f_cnt_reg    <= '0;
      f2h_wr_ptr_reg <= '0;
      f2h_rd_ptr_reg <= '0;
      f2h_cnt_reg    <= '0;
      ft_rxf_reg     <= 1'b1;
      ft_txe_reg     <= 1'b1;
      err_reg        <= 1'b0;
    end else begin
      h2f_wr_ptr_reg <= h2f_wr_ptr_reg + H2F_DEPTH_W'(h2f_push);
      h2f_rd_ptr_reg <= h2f_rd_ptr_reg + H2F_DEPTH_W'(h2f_pop_n);
      h2f_cnt_reg    <= h2f_cnt_next;
      f2h_wr_ptr_reg <= f2h_wr_ptr_reg + F2H_DEPTH_W'(lane0_ok) + F2H_DEPTH_W'(lane1_ok);
      f2h_rd_ptr_reg <= f2h_rd_ptr_reg + F2H_DEPTH_W'(f2h_pop);
      f2h_cnt_reg    <= f2h_cnt_next;
      // Flags follow the post-update counts, so they lag the data by one cycle.
      ft_rxf_reg     <= (h2f_cnt_next == '0);
      ft_txe_reg     <= ((F2H_FULL - f2h_cnt_next) < F2H_CNT_TWO);
      err_reg        <= err_reg || contention || drop;
    end
  end
endmodule
